// File: rtl/fpu_align.sv
// fpu_align -- pre-add operand alignment for the FPU adder path.
//
// Takes two packed operands and orders them by magnitude. It then shifts the
// smaller significand right one bit per cycle until both operands share the
// larger exponent. Significands are emitted as {hidden, fraction, OFF ext bits},
// which is the extended format the post-operation normaliser consumes.
//
// Build option: FPU_ALIGN_STICKY_EN
//   defined   -> bit 0 of small_f accumulates the OR of every shifted-out bit,
//                and a collapsed operand becomes sticky = (significand != 0).
//   undefined -> plain logical right shift; a collapsed operand becomes 0.
//   Latency is the same in both builds.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               capture operands (honoured only when idle)
//   a_s/a_e/a_f         operand a sign, biased exponent, stored fraction
//   b_s/b_e/b_f         operand b sign, biased exponent, stored fraction
//   big_s, small_s      signs of the larger / smaller magnitude operand
//   big_f, small_f      extended significands, F+OFF+1 bits
//   result_e            common (larger effective) exponent
//   swapped             1 when b was the larger magnitude
//   busy                aligning, or a start is being accepted this cycle
//   done                one-cycle pulse, outputs valid
module fpu_align #(
  parameter int WIDTH = 32,
  parameter int E     = 8,
  parameter int F     = 23,
  parameter int OFF   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_s,
  input  logic [E-1:0]     a_e,
  input  logic [F-1:0]     a_f,
  input  logic             b_s,
  input  logic [E-1:0]     b_e,
  input  logic [F-1:0]     b_f,
  output logic             big_s,
  output logic             small_s,
  output logic [F+OFF:0]   big_f,
  output logic [F+OFF:0]   small_f,
  output logic [E-1:0]     result_e,
  output logic             swapped,
  output logic             busy,
  output logic             done
);

  localparam int SW = F + OFF + 1;

  // The packed width is derived from the field widths; catch a mismatched
  // instantiation at elaboration time.
  if (WIDTH != 1 + E + F) begin : g_width_check
    $error("fpu_align: WIDTH must equal 1+E+F");
  end

  typedef enum logic {IDLE, ALIGN} state_t;

  state_t         state, state_next;
  logic [E-1:0]   cnt;
  logic           load, shift, finish;

  // Capture-side decode of both operands.
  logic           a_hid, b_hid, b_gt;
  logic [E-1:0]   a_eff, b_eff, big_eff, small_eff, diff;
  logic [E+F:0]   a_key, b_key;
  logic [F:0]     big_sig, small_sig;
  logic           collapse;
  logic [SW-1:0]  collapse_f, cap_small_f, shift_f;
  logic [E-1:0]   cap_cnt;

  // Subnormals (e == 0) have no hidden bit and behave as exponent 1. Magnitude
  // ordering is a plain unsigned compare of {eff_e, hidden, f}; ties keep a big.
  always_comb begin
    a_hid     = |a_e;
    b_hid     = |b_e;
    a_eff     = a_hid ? a_e : E'(1);
    b_eff     = b_hid ? b_e : E'(1);
    a_key     = {a_eff, a_hid, a_f};
    b_key     = {b_eff, b_hid, b_f};
    b_gt      = b_key > a_key;
    big_eff   = b_gt ? b_eff : a_eff;
    small_eff = b_gt ? a_eff : b_eff;
    big_sig   = b_gt ? {b_hid, b_f} : {a_hid, a_f};
    small_sig = b_gt ? {a_hid, a_f} : {b_hid, b_f};
    diff      = big_eff - small_eff;
  end

  // A shift distance of the whole significand width or more would leave
  // nothing; collapse it at capture and leave a single no-op shift so the
  // latency stays short and bounded. A one-bit collapsed value survives that
  // extra shift unchanged because the sticky OR keeps bit 0.
  always_comb begin
    collapse   = 32'(diff) >= 32'(SW);
`ifdef FPU_ALIGN_STICKY_EN
    collapse_f = {{(SW-1){1'b0}}, |small_sig};
`else
    collapse_f = '0;
`endif
    cap_small_f = collapse ? collapse_f : {small_sig, {OFF{1'b0}}};
    cap_cnt     = collapse ? E'(1) : diff;
  end

  // One-bit right shift of the smaller significand; with sticky enabled the
  // bit falling off the end is folded into the new bit 0.
  always_comb begin
    shift_f = {1'b0, small_f[SW-1:1]};
`ifdef FPU_ALIGN_STICKY_EN
    shift_f[0] = small_f[1] | small_f[0];
`endif
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          shift = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath registers. Outputs hold in IDLE until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      big_s    <= 1'b0;
      small_s  <= 1'b0;
      big_f    <= '0;
      small_f  <= '0;
      result_e <= '0;
      swapped  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        big_s    <= b_gt ? b_s : a_s;
        small_s  <= b_gt ? a_s : b_s;
        big_f    <= {big_sig, {OFF{1'b0}}};
        small_f  <= cap_small_f;
        result_e <= big_eff;
        swapped  <= b_gt;
        cnt      <= cap_cnt;
      end else if (shift) begin
        small_f <= shift_f;
        cnt     <= cnt - E'(1);
      end
    end
  end

  assign busy = (state == ALIGN) | (start & ~rst);

endmodule

// File: tb/tb_fpu_align.sv
// tb_fpu_align -- self-checking bench for fpu_align (default parameters).
// Directed cases from the alignment scenarios plus randomized operands
// checked against an arithmetic reference model.
module tb_fpu_align;

  localparam int E   = 8;
  localparam int F   = 23;
  localparam int OFF = 3;
  localparam int SW  = F + OFF + 1;

`ifdef FPU_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          a_s, b_s;
  logic [E-1:0]  a_e, b_e;
  logic [F-1:0]  a_f, b_f;
  logic          big_s, small_s;
  logic [SW-1:0] big_f, small_f;
  logic [E-1:0]  result_e;
  logic          swapped, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          big_s;
    logic          small_s;
    logic [SW-1:0] big_f;
    logic [SW-1:0] small_f;
    logic [E-1:0]  result_e;
    logic          swapped;
    int            lat;
  } exp_t;

  always #5 clk = ~clk;

  fpu_align dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_s      (a_s),
    .a_e      (a_e),
    .a_f      (a_f),
    .b_s      (b_s),
    .b_e      (b_e),
    .b_f      (b_f),
    .big_s    (big_s),
    .small_s  (small_s),
    .big_f    (big_f),
    .small_f  (small_f),
    .result_e (result_e),
    .swapped  (swapped),
    .busy     (busy),
    .done     (done)
  );

  // Reference: magnitudes as integers, alignment as division by 2**d with the
  // remainder deciding the sticky bit.
  function automatic exp_t refModel(input logic as_i, input logic [E-1:0] ae, input logic [F-1:0] af,
                                    input logic bs_i, input logic [E-1:0] be, input logic [F-1:0] bf);
    exp_t   r;
    longint ea, eb, ma, mb, ebig, esmall, mbig, msmall, d, sig, kept, lost, scale;
    bit     b_bigger;
    ea = (ae == 0) ? 1 : longint'(ae);
    eb = (be == 0) ? 1 : longint'(be);
    ma = ((ae == 0) ? 0 : (longint'(1) << F)) + longint'(af);
    mb = ((be == 0) ? 0 : (longint'(1) << F)) + longint'(bf);
    b_bigger = (eb > ea) || ((eb == ea) && (mb > ma));
    ebig   = b_bigger ? eb : ea;
    esmall = b_bigger ? ea : eb;
    mbig   = b_bigger ? mb : ma;
    msmall = b_bigger ? ma : mb;
    d      = ebig - esmall;
    scale  = longint'(1) << OFF;
    sig    = msmall * scale;
    if (d >= SW) begin
      kept  = 0;
      lost  = sig;
      r.lat = 2;
    end else begin
      kept  = sig / (longint'(1) << d);
      lost  = sig % (longint'(1) << d);
      r.lat = int'(d) + 1;
    end
    if (STICKY && lost != 0) kept = kept | 1;
    r.big_s    = b_bigger ? bs_i : as_i;
    r.small_s  = b_bigger ? as_i : bs_i;
    r.big_f    = SW'(mbig * scale);
    r.small_f  = SW'(kept);
    r.result_e = E'(ebig);
    r.swapped  = b_bigger;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive operands with start for exactly one active edge (edge 0).
  task automatic applyStimulus(input logic as_i, input logic [E-1:0] ae, input logic [F-1:0] af,
                               input logic bs_i, input logic [E-1:0] be, input logic [F-1:0] bf);
    a_s = as_i; a_e = ae; a_f = af;
    b_s = bs_i; b_e = be; b_f = bf;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles since edge 0 until done is seen, bounded.
  task automatic waitDone(input string tag, input int already, output int lat);
    bit got;
    got = 1'b0;
    lat = already;
    while (!got && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) got = 1'b1;
    end
    checkOutput({tag, ".done_seen"}, 64'(got), 64'(1));
  endtask

  task automatic checkFields(input string tag, input exp_t x, input int lat);
    checkOutput({tag, ".big_s"},    64'(big_s),    64'(x.big_s));
    checkOutput({tag, ".small_s"},  64'(small_s),  64'(x.small_s));
    checkOutput({tag, ".big_f"},    64'(big_f),    64'(x.big_f));
    checkOutput({tag, ".small_f"},  64'(small_f),  64'(x.small_f));
    checkOutput({tag, ".result_e"}, 64'(result_e), 64'(x.result_e));
    checkOutput({tag, ".swapped"},  64'(swapped),  64'(x.swapped));
    checkOutput({tag, ".latency"},  64'(lat),      64'(x.lat));
  endtask

  // One cycle after done: pulse gone, idle, outputs holding.
  task automatic checkIdleHold(input string tag, input exp_t x);
    @(posedge clk);
    #1;
    checkOutput({tag, ".done_pulse"}, 64'(done),    64'(0));
    checkOutput({tag, ".idle_busy"},  64'(busy),    64'(0));
    checkOutput({tag, ".hold"},       64'(small_f), 64'(x.small_f));
  endtask

  task automatic runOp(input string tag, input logic as_i, input logic [E-1:0] ae, input logic [F-1:0] af,
                       input logic bs_i, input logic [E-1:0] be, input logic [F-1:0] bf);
    exp_t x;
    int   lat;
    x = refModel(as_i, ae, af, bs_i, be, bf);
    applyStimulus(as_i, ae, af, bs_i, be, bf);
    waitDone(tag, 0, lat);
    checkFields(tag, x, lat);
    checkIdleHold(tag, x);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t x, y;
    int   lat, t;
    bit   saw_done;
    logic [E-1:0] re_a, re_b;
    logic [F-1:0] rf_a, rf_b;

    rst = 1'b1; start = 1'b0;
    a_s = 1'b0; a_e = '0; a_f = '0;
    b_s = 1'b0; b_e = '0; b_f = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.big_f",    64'(big_f),    64'(0));
    checkOutput("reset.small_f",  64'(small_f),  64'(0));
    checkOutput("reset.result_e", 64'(result_e), 64'(0));
    checkOutput("reset.swapped",  64'(swapped),  64'(0));
    checkOutput("reset.signs",    64'({big_s, small_s}), 64'(0));
    checkOutput("reset.done",     64'(done),     64'(0));
    checkOutput("reset.busy",     64'(busy),     64'(0));

    // rst wins over start: busy stays low and no operation is captured.
    a_e = 8'd130; b_e = 8'd120;
    start = 1'b1;
    #1;
    checkOutput("rst_prio.busy_comb", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    #1;
    checkOutput("rst_prio.no_capture", 64'(busy), 64'(0));
    @(negedge clk);

    // Directed scenarios.
    runOp("t1", 1'b0, 8'd127, 23'd0, 1'b0, 8'd126, 23'd0);
    checkOutput("t1.big_f_const",   64'(big_f),   64'(27'h4000000));
    checkOutput("t1.small_f_const", 64'(small_f), 64'(27'h2000000));

    runOp("t2", 1'b0, 8'd126, 23'd0, 1'b1, 8'd127, 23'd0);
    checkOutput("t2.swapped_const", 64'(swapped), 64'(1));
    checkOutput("t2.big_s_const",   64'(big_s),   64'(1));

    runOp("t3", 1'b0, 8'd129, 23'd0, 1'b0, 8'd124, 23'd1);
    checkOutput("t3.small_f_const", 64'(small_f), STICKY ? 64'(27'h200001) : 64'(27'h200000));

    runOp("t4", 1'b0, 8'd200, 23'd0, 1'b0, 8'd100, 23'd0);
    checkOutput("t4.small_f_const",  64'(small_f),  STICKY ? 64'(1) : 64'(0));
    checkOutput("t4.result_e_const", 64'(result_e), 64'(200));

    runOp("t5", 1'b0, 8'd127, 23'd5, 1'b1, 8'd127, 23'd5);
    checkOutput("t5.swapped_const", 64'(swapped), 64'(0));

    // A second start during a d=10 alignment is ignored.
    rf_a = F'($urandom);
    rf_b = F'($urandom);
    x = refModel(1'b0, 8'd137, rf_a, 1'b1, 8'd127, rf_b);
    applyStimulus(1'b0, 8'd137, rf_a, 1'b1, 8'd127, rf_b);
    repeat (3) @(posedge clk);
    #1;
    a_e = 8'd10; b_e = 8'd250; a_f = 23'h7fffff; b_f = 23'h1;
    start = 1'b1;
    #1;
    checkOutput("ignore.busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignore", 4, lat);
    checkFields("ignore", x, lat);
    checkIdleHold("ignore", x);

    // start in the same cycle as done is accepted.
    x = refModel(1'b1, 8'd50, 23'h12345, 1'b0, 8'd47, 23'h54321);
    y = refModel(1'b0, 8'd0, 23'h400001, 1'b0, 8'd3, 23'h000100);
    applyStimulus(1'b1, 8'd50, 23'h12345, 1'b0, 8'd47, 23'h54321);
    waitDone("b2b_first", 0, lat);
    checkFields("b2b_first", x, lat);
    applyStimulus(1'b0, 8'd0, 23'h400001, 1'b0, 8'd3, 23'h000100);
    waitDone("b2b_second", 0, lat);
    checkFields("b2b_second", y, lat);
    checkIdleHold("b2b_second", y);

    // Reset mid-alignment aborts without done.
    applyStimulus(1'b1, 8'd140, 23'h00abcd, 1'b0, 8'd130, 23'h3fffff);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort.big_f",    64'(big_f),    64'(0));
    checkOutput("abort.small_f",  64'(small_f),  64'(0));
    checkOutput("abort.result_e", 64'(result_e), 64'(0));
    checkOutput("abort.flags",    64'({big_s, small_s, swapped}), 64'(0));
    checkOutput("abort.busy",     64'(busy),     64'(0));
    checkOutput("abort.done",     64'(done),     64'(0));
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("abort.no_done", 64'(saw_done), 64'(0));
    runOp("after_abort", 1'b0, 8'd140, 23'h00abcd, 1'b1, 8'd130, 23'h3fffff);

    // Randomized operands covering equal, near, far and subnormal exponents.
    for (int i = 0; i < 40; i++) begin
      re_a = E'($urandom_range(0, 255));
      rf_a = F'($urandom);
      rf_b = F'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          re_b = re_a;
          if ($urandom_range(0, 1) == 1) rf_b = rf_a;
        end
        1: re_b = E'($urandom_range(0, 255));
        2: begin
          t = int'(re_a) - int'($urandom_range(0, 30));
          if (t < 0) t = 0;
          re_b = E'(t);
        end
        default: begin
          re_a = E'($urandom_range(0, 4));
          re_b = 8'd0;
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        runOp("rand", 1'($urandom), re_b, rf_b, 1'($urandom), re_a, rf_a);
      end else begin
        runOp("rand", 1'($urandom), re_a, rf_a, 1'($urandom), re_b, rf_b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_align.md
# fpu_align

Pre-add operand alignment unit for the FPU adder path. It is the counterpart of the post-operation normaliser: it takes two packed operands and orders them by magnitude. It then right-shifts the smaller significand one bit per cycle until both share the larger exponent, and emits extended significands in the same `F+OFF+1`-bit format the normaliser consumes. Guard, round and sticky bits are kept in the low `OFF` bits.

## Interface
- `WIDTH`, 32: packed operand width (informational; `WIDTH = 1+E+F`).
- `E`, 8: exponent width.
- `F`, 23: stored fraction width.
- `OFF`, 3: extension bits below fraction (`[OFF-1]` guard … `[0]` sticky).
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  capture operands; honoured only when idle.
- `a_s`, `b_s`  in  1  operand signs.
- `a_e`, `b_e`  in  E  biased exponents.
- `a_f`, `b_f`  in  F  stored fractions.
- `big_s`, `small_s`  out  1  signs of larger/smaller-magnitude operand.
- `big_f`, `small_f`  out  F+OFF+1  extended significands `{hidden, fraction, OFF ext bits}`.
- `result_e`  out  E  common (larger effective) exponent.
- `swapped`  out  1  1 when b was larger magnitude.
- `busy`  out  1  `(state==ALIGN) | (start & ~rst)`.
- `done`  out  1  one-cycle pulse, outputs valid.

## Operation
- States: `IDLE`, `ALIGN`.
- IDLE + `start`: the following is captured and the state moves to ALIGN.
  - Hidden bit = `(e != 0)`; effective exponent = `e` if nonzero, else 1 (subnormal).
  - Operands are compared on `{eff_e, hidden, f}`. b strictly greater sets `swapped=1`. Ties keep a as big.
  - `big_f`/`small_f` are loaded `{hidden, f, OFF'b0}`.
  - `result_e` = big effective exponent.
  - `cnt` = `eff_e_big − eff_e_small` (E bits, never negative).
- On `start`, if `cnt ≥ F+OFF+1`, collapse immediately at capture:
  - `small_f` = `{0…, (small significand != 0)}` with the macro, 0 without.
  - `cnt` = 1, and is consumed as a no-op shift.
- ALIGN, each edge:
  - `cnt==0`: go to IDLE and set `done`=1 for one cycle.
  - Otherwise: `small_f` shifts right by 1, `small_f[0]` = shifted-out bit OR old `small_f[0]` (sticky), then `cnt--`.
- `big_f`, `big_s`, `result_e`, `swapped` do not change during ALIGN.
- Inf/NaN (exponent all ones) are not special-cased. They are aligned arithmetically; the adder handles them.
- `start` while in ALIGN is ignored. A captured operation always completes.
- Outputs hold their last values in IDLE until the next accepted `start`.

## Timing
- `start` is sampled at edge 0. Shift edges are 1…d. `done` is registered high after edge d+1, i.e. for the cycle following edge d+1.
- Latency: d+1 cycles from the start edge to `done`. Equal exponents give 1 cycle. A collapse gives 2 cycles. Maximum is `F+OFF+1` cycles.
- `start` may be asserted in the same cycle `done` is high; it is accepted, since the state is already IDLE.
- Reset:
  - All outputs are 0, state is IDLE, `done`=0, `busy`=0.
  - `rst` asserted mid-ALIGN aborts the operation: no `done`, outputs are zeroed on the next edge.
  - `rst` has priority over `start`.

## Configuration
- `FPU_ALIGN_STICKY_EN` defined: bit 0 of `small_f` accumulates the OR of all shifted-out bits, and a collapse yields sticky = nonzero.
- `FPU_ALIGN_STICKY_EN` undefined: a plain logical right shift; shifted-out bits are dropped and a collapse yields 0.
- Latency is identical in both builds.

## Test plan
All scenarios use defaults F=23, OFF=3, significand width 27.

- a=1.0 (e=127, f=0), b=0.5 (e=126, f=0), start → `swapped`=0, `result_e`=127, `big_f`=27'h4000000, `small_f`=27'h2000000, `done` 2 cycles after start.
- a=0.5, b=1.0 → `swapped`=1, `big_s`=`b_s`, `result_e`=127, `big_f`=27'h4000000, `small_f`=27'h2000000.
- a: e=129, f=0; b: e=124, f=1 (d=5) → `small_f`=27'h200001 with macro, 27'h200000 without; `done` 6 cycles after start.
- a: e=200; b: e=100, f=0 (collapse) → `small_f`=27'h0000001 with macro, 0 without; `done` 2 cycles after start; `result_e`=200.
- Equal operands e=127, f=5 → `swapped`=0, `done` 1 cycle after start; a second `start` pulsed during a d=10 alignment is ignored; the second operation starts only after `done`.
- d=10 operation with `rst` asserted 3 cycles after start → `done` never pulses; all outputs and `busy` are 0 the following cycle; `start` after `rst` deasserts completes normally.
